// File: rtl/tag_lookup_stage.sv
// Direct-mapped tag directory lookup stage with fill/flush and hit/miss stats.
// Ports: clk/reset; io_req_* request in; io_resp_* response out;
//        io_fill_* and io_flush from refill side; io_hit_cnt/io_miss_cnt.
module tag_lookup_stage #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             io_req_ready,
    input  logic             io_req_valid,
    input  logic [IDX_W-1:0] io_req_bits_idx,
    input  logic [TAG_W-1:0] io_req_bits_tag,
    input  logic             io_resp_ready,
    output logic             io_resp_valid,
    output logic             io_resp_bits_hit,
    output logic [IDX_W-1:0] io_resp_bits_idx,
    output logic [TAG_W-1:0] io_resp_bits_tag,
    input  logic             io_fill_valid,
    input  logic [IDX_W-1:0] io_fill_idx,
    input  logic [TAG_W-1:0] io_fill_tag,
    input  logic             io_flush,
    output logic [CNT_W-1:0] io_hit_cnt,
    output logic [CNT_W-1:0] io_miss_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic             resp_valid_q;
    logic [IDX_W-1:0] cap_idx_q;
    logic [TAG_W-1:0] cap_tag_q;
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic accept;
    logic retire;
    logic hit;

    assign io_req_ready = !resp_valid_q | io_resp_ready;
    assign accept       = io_req_valid & io_req_ready;
    assign retire       = resp_valid_q & io_resp_ready;

    // Hit tracks the live directory so fills/flushes during a stall show up.
    assign hit = valid_q[cap_idx_q] & (tag_mem[cap_idx_q] == cap_tag_q);

    assign io_resp_valid    = resp_valid_q;
    assign io_resp_bits_hit = hit;
    assign io_resp_bits_idx = cap_idx_q;
    assign io_resp_bits_tag = cap_tag_q;
    assign io_hit_cnt       = hit_cnt_q;
    assign io_miss_cnt      = miss_cnt_q;

    // Flush wins over a same-edge fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (io_flush) begin
            valid_q <= '0;
        end else if (io_fill_valid) begin
            valid_q[io_fill_idx] <= 1'b1;
        end
    end

    // Tag payload needs no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (io_fill_valid && !io_flush) begin
            tag_mem[io_fill_idx] <= io_fill_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            cap_idx_q    <= '0;
            cap_tag_q    <= '0;
        end else begin
            if (accept) begin
                resp_valid_q <= 1'b1;
                cap_idx_q    <= io_req_bits_idx;
                cap_tag_q    <= io_req_bits_tag;
            end else if (retire) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (retire) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tag_lookup_stage.sv
// Directed self-checking bench for tag_lookup_stage.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_tag_lookup_stage;

    localparam int IDX_W = 6;
    localparam int TAG_W = 20;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             io_req_ready;
    logic             io_req_valid;
    logic [IDX_W-1:0] io_req_bits_idx;
    logic [TAG_W-1:0] io_req_bits_tag;
    logic             io_resp_ready;
    logic             io_resp_valid;
    logic             io_resp_bits_hit;
    logic [IDX_W-1:0] io_resp_bits_idx;
    logic [TAG_W-1:0] io_resp_bits_tag;
    logic             io_fill_valid;
    logic [IDX_W-1:0] io_fill_idx;
    logic [TAG_W-1:0] io_fill_tag;
    logic             io_flush;
    logic [CNT_W-1:0] io_hit_cnt;
    logic [CNT_W-1:0] io_miss_cnt;

    int checks = 0;
    int errors = 0;

    tag_lookup_stage #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .io_req_ready     (io_req_ready),
        .io_req_valid     (io_req_valid),
        .io_req_bits_idx  (io_req_bits_idx),
        .io_req_bits_tag  (io_req_bits_tag),
        .io_resp_ready    (io_resp_ready),
        .io_resp_valid    (io_resp_valid),
        .io_resp_bits_hit (io_resp_bits_hit),
        .io_resp_bits_idx (io_resp_bits_idx),
        .io_resp_bits_tag (io_resp_bits_tag),
        .io_fill_valid    (io_fill_valid),
        .io_fill_idx      (io_fill_idx),
        .io_fill_tag      (io_fill_tag),
        .io_flush         (io_flush),
        .io_hit_cnt       (io_hit_cnt),
        .io_miss_cnt      (io_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_req_valid = 1'b0;
        io_req_bits_idx = '0;
        io_req_bits_tag = '0;
        io_resp_ready = 1'b1;
        io_fill_valid = 1'b0;
        io_fill_idx = '0;
        io_fill_tag = '0;
        io_flush = 1'b0;
        #12;
        checks++;
        if (io_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", io_resp_valid);
        end
        checks++;
        if (io_hit_cnt !== 16'h0 || io_miss_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h/%h exp 0/0", io_hit_cnt, io_miss_cnt);
        end
        checks++;
        if (io_resp_bits_idx !== 6'd0 || io_resp_bits_tag !== 20'h0) begin
            errors++;
            $display("FAIL reset_bits got %h/%h exp 0/0",
                     io_resp_bits_idx, io_resp_bits_tag);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (io_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", io_req_ready);
        end
    endtask

    task automatic test_first_miss();
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd5;
        io_req_bits_tag = 20'h12345;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_hit !== 1'b0 ||
            io_resp_bits_idx !== 6'd5 || io_resp_bits_tag !== 20'h12345) begin
            errors++;
            $display("FAIL first_resp got v%b h%b %h %h exp v1 h0 05 12345",
                     io_resp_valid, io_resp_bits_hit,
                     io_resp_bits_idx, io_resp_bits_tag);
        end
        step();
        checks++;
        if (io_resp_valid !== 1'b0 || io_miss_cnt !== 16'd1 ||
            io_hit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL first_retire got v%b miss %0d hit %0d exp v0 1 0",
                     io_resp_valid, io_miss_cnt, io_hit_cnt);
        end
    endtask

    task automatic test_fill_hit();
        io_fill_valid = 1'b1;
        io_fill_idx = 6'd5;
        io_fill_tag = 20'h12345;
        step();
        io_fill_valid = 1'b0;
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd5;
        io_req_bits_tag = 20'h12345;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_bits_hit !== 1'b1) begin
            errors++;
            $display("FAIL fill_hit got %b exp 1", io_resp_bits_hit);
        end
        step();
        checks++;
        if (io_hit_cnt !== 16'd1) begin
            errors++;
            $display("FAIL fill_hit_cnt got %0d exp 1", io_hit_cnt);
        end
        io_req_valid = 1'b1;
        io_req_bits_tag = 20'h12346;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_hit !== 1'b0) begin
            errors++;
            $display("FAIL tag_mismatch got v%b h%b exp v1 h0",
                     io_resp_valid, io_resp_bits_hit);
        end
        step();
        checks++;
        if (io_miss_cnt !== 16'd2) begin
            errors++;
            $display("FAIL mismatch_cnt got %0d exp 2", io_miss_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            io_req_valid = 1'b1;
            io_req_bits_idx = 6'(i);
            io_req_bits_tag = 20'h100 + 20'(i);
            #1;
            checks++;
            if (io_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got %b exp 1", i, io_req_ready);
            end
            step();
            checks++;
            if (io_resp_valid !== 1'b1 || io_resp_bits_idx !== 6'(i) ||
                io_resp_bits_tag !== 20'h100 + 20'(i)) begin
                errors++;
                $display("FAIL b2b_resp[%0d] got v%b %h %h exp v1 %h %h", i,
                         io_resp_valid, io_resp_bits_idx, io_resp_bits_tag,
                         6'(i), 20'h100 + 20'(i));
            end
        end
        io_req_valid = 1'b0;
        step();
        checks++;
        if (io_resp_valid !== 1'b0 || io_miss_cnt !== 16'd10 ||
            io_hit_cnt !== 16'd1) begin
            errors++;
            $display("FAIL b2b_cnt got v%b miss %0d hit %0d exp v0 10 1",
                     io_resp_valid, io_miss_cnt, io_hit_cnt);
        end
    endtask

    task automatic test_stall_fill();
        io_resp_ready = 1'b0;
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd20;
        io_req_bits_tag = 20'hABCDE;
        step();
        io_req_bits_idx = 6'd21;
        io_req_bits_tag = 20'h11111;
        checks++;
        if (io_resp_valid !== 1'b1 || io_req_ready !== 1'b0 ||
            io_resp_bits_hit !== 1'b0) begin
            errors++;
            $display("FAIL stall_enter got v%b r%b h%b exp v1 r0 h0",
                     io_resp_valid, io_req_ready, io_resp_bits_hit);
        end
        io_fill_valid = 1'b1;
        io_fill_idx = 6'd20;
        io_fill_tag = 20'hABCDE;
        step();
        io_fill_valid = 1'b0;
        checks++;
        if (io_resp_bits_hit !== 1'b1) begin
            errors++;
            $display("FAIL stall_fill_hit got %b exp 1", io_resp_bits_hit);
        end
        step();
        checks++;
        if (io_resp_bits_idx !== 6'd20 || io_resp_bits_tag !== 20'hABCDE ||
            io_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got v%b %h %h exp v1 14 abcde",
                     io_resp_valid, io_resp_bits_idx, io_resp_bits_tag);
        end
        io_req_valid = 1'b0;
        io_resp_ready = 1'b1;
        #1;
        checks++;
        if (io_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready_comb got %b exp 1", io_req_ready);
        end
        step();
        checks++;
        if (io_resp_valid !== 1'b0 || io_hit_cnt !== 16'd2 ||
            io_miss_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stall_release got v%b hit %0d miss %0d exp v0 2 10",
                     io_resp_valid, io_hit_cnt, io_miss_cnt);
        end
    endtask

    task automatic test_flush_fill();
        io_fill_valid = 1'b1;
        io_fill_idx = 6'd9;
        io_fill_tag = 20'h00099;
        io_flush = 1'b1;
        step();
        io_fill_valid = 1'b0;
        io_flush = 1'b0;
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd9;
        io_req_bits_tag = 20'h00099;
        step();
        checks++;
        if (io_resp_bits_hit !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill_9 got %b exp 0", io_resp_bits_hit);
        end
        io_req_bits_idx = 6'd20;
        io_req_bits_tag = 20'hABCDE;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_bits_hit !== 1'b0 || io_resp_bits_idx !== 6'd20) begin
            errors++;
            $display("FAIL flush_20 got h%b %h exp h0 14",
                     io_resp_bits_hit, io_resp_bits_idx);
        end
        step();
        checks++;
        if (io_hit_cnt !== 16'd2 || io_miss_cnt !== 16'd12) begin
            errors++;
            $display("FAIL flush_cnt got hit %0d miss %0d exp 2 12",
                     io_hit_cnt, io_miss_cnt);
        end
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd30;
        io_req_bits_tag = 20'h00030;
        io_fill_valid = 1'b1;
        io_fill_idx = 6'd30;
        io_fill_tag = 20'h00030;
        step();
        io_req_valid = 1'b0;
        io_fill_valid = 1'b0;
        checks++;
        if (io_resp_bits_hit !== 1'b1) begin
            errors++;
            $display("FAIL same_edge_fill got %b exp 1", io_resp_bits_hit);
        end
        step();
        checks++;
        if (io_hit_cnt !== 16'd3) begin
            errors++;
            $display("FAIL same_edge_cnt got %0d exp 3", io_hit_cnt);
        end
    endtask

    task automatic test_saturate_reset();
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd0;
        io_req_bits_tag = 20'h55555;
        repeat (65540) step();
        checks++;
        if (io_miss_cnt !== 16'hFFFF || io_hit_cnt !== 16'd3) begin
            errors++;
            $display("FAIL saturate got miss %h hit %0d exp ffff 3",
                     io_miss_cnt, io_hit_cnt);
        end
        io_resp_ready = 1'b0;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_miss_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_stall got v%b miss %h exp v1 ffff",
                     io_resp_valid, io_miss_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (io_resp_valid !== 1'b0 || io_hit_cnt !== 16'd0 ||
            io_miss_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got v%b hit %h miss %h exp v0 0 0",
                     io_resp_valid, io_hit_cnt, io_miss_cnt);
        end
        step();
        reset = 1'b0;
        io_resp_ready = 1'b1;
        io_req_valid = 1'b1;
        io_req_bits_idx = 6'd30;
        io_req_bits_tag = 20'h00030;
        step();
        io_req_valid = 1'b0;
        checks++;
        if (io_resp_valid !== 1'b1 || io_resp_bits_hit !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_dir got v%b h%b exp v1 h0",
                     io_resp_valid, io_resp_bits_hit);
        end
        step();
        checks++;
        if (io_miss_cnt !== 16'd1 || io_hit_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_cnt got miss %0d hit %0d exp 1 0",
                     io_miss_cnt, io_hit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_fill_hit();
        test_back_to_back();
        test_stall_fill();
        test_flush_fill();
        test_saturate_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_lookup_stage.md
Name: tag_lookup_stage

Overview:
- Direct-mapped tag directory stage fed by the 2-input idx/tag request arbiter; consumes its io_out handshake and bits.
- Holds 2^IDX_W entries of {valid, tag}.
- Answers each request one cycle later with hit/miss; takes fills and a global flush from the refill side.
- Keeps saturating hit/miss statistics counters.

Parameters:
- IDX_W, 6, set index width; directory depth = 2^IDX_W (64)
- TAG_W, 20, tag width
- CNT_W, 16, width of hit/miss statistics counters

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- io_req_ready  out  1  stage can accept a request this cycle
- io_req_valid  in  1  request valid (from arbiter io_out_valid)
- io_req_bits_idx  in  IDX_W  set index
- io_req_bits_tag  in  TAG_W  tag to compare
- io_resp_ready  in  1  consumer accepts response
- io_resp_valid  out  1  response held in output register
- io_resp_bits_hit  out  1  entry[idx] valid and tag matches
- io_resp_bits_idx  out  IDX_W  captured index
- io_resp_bits_tag  out  TAG_W  captured tag
- io_fill_valid  in  1  write {valid=1, tag} into entry io_fill_idx; always accepted
- io_fill_idx  in  IDX_W  fill set index
- io_fill_tag  in  TAG_W  fill tag
- io_flush  in  1  clear every valid bit
- io_hit_cnt  out  CNT_W  responses delivered with hit=1
- io_miss_cnt  out  CNT_W  responses delivered with hit=0

Behaviour:
- Reset values (asynchronous, take effect without a clock edge):
  - all entry valid bits = 0; tag storage is don't-care.
  - io_resp_valid = 0; captured idx/tag = 0.
  - io_hit_cnt = io_miss_cnt = 0.
  - io_req_ready is 1 as soon as reset deasserts.
- Handshake:
  - io_req_ready = !io_resp_valid | io_resp_ready. Combinational from io_resp_ready; no combinational path from io_req_valid.
  - Request accepted on the edge where io_req_valid & io_req_ready. idx/tag are captured into the output register and io_resp_valid = 1 the next cycle. Latency is exactly 1 cycle.
  - Response retires on the edge where io_resp_valid & io_resp_ready. With no new accept on that edge, io_resp_valid returns to 0.
  - Retire and accept on the same edge: the register reloads and io_resp_valid stays 1. Full throughput is 1 request/cycle.
  - While stalled (io_resp_valid & !io_resp_ready), io_resp_bits_idx/tag hold stable.
- Hit evaluation:
  - io_resp_bits_hit = valid[cap_idx] & (tag[cap_idx] == cap_tag), evaluated combinationally every cycle against the current directory.
  - A fill or flush landing while a response is stalled updates hit on the following cycle. The value counted is the one present at the retire edge.
- Directory updates:
  - Fill writes entry io_fill_idx on the edge: valid=1, tag=io_fill_tag.
  - Fill on the same edge as a request accept to the same idx: the response sees the filled entry next cycle.
  - io_flush clears all valid bits on the edge and has priority over a same-cycle fill; that fill is dropped.
  - Fill overwrites any existing entry (no victim reporting).
  - Flush and fill do not affect request/response handshake state.
- Counters:
  - On each retire edge, increment io_hit_cnt if hit=1, else io_miss_cnt.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - Counters are not cleared by io_flush; only reset clears them.
- Reset mid-operation: a pending response is discarded (io_resp_valid=0), the directory is invalidated and the counters are zeroed; no response is produced for in-flight requests.

Test Plan:
- Reset, then req idx=5 tag=0x12345 with resp_ready=1 -> next cycle resp_valid=1, hit=0, idx=5, tag=0x12345; miss_cnt=1, hit_cnt=0.
- Fill idx=5 tag=0x12345, then same req -> hit=1; hit_cnt increments to 1. Req idx=5 tag=0x12346 -> hit=0.
- Back-to-back reqs idx=0..7 every cycle, resp_ready=1 -> 8 responses on consecutive cycles, req_ready constantly 1.
- Hold resp_ready=0 with a response valid -> req_ready=0, bits stable. Fill the matching entry during the stall -> hit flips 0->1 the next cycle. Release -> hit_cnt increments once.
- Same-cycle fill idx=9 and flush -> entry 9 invalid; a subsequent req on idx=9 returns hit=0.
- Preload miss_cnt near 0xFFFF via 65540 misses -> saturates at 0xFFFF. Assert reset mid-stall -> resp_valid=0 and counters=0 immediately, before the next clk edge.
